// File: rtl/quad_enc_multi.sv
// Multi-channel quadrature encoder front end: sync, debounce, full-step decode, bounded count.
// Optional step acceleration is compiled in with the ENC_ACCEL_EN macro.
module quad_enc_multi #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 5,
  parameter int unsigned MAX_COUNT    = 31,
  parameter int unsigned DEB_CYCLES   = 1000,
  parameter int unsigned WRAP_MODE    = 1,
  parameter int unsigned ACCEL_WINDOW = 200000,
  parameter int unsigned ACCEL_STEP   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       a_in,
  input  logic [NUM_CH-1:0]       b_in,
  input  logic [NUM_CH-1:0]       btn_in,
  input  logic [NUM_CH-1:0]       en,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH*2-1:0]     dir_out,
  output logic [NUM_CH-1:0]       step_pulse,
  output logic [NUM_CH-1:0]       btn_pulse
);

  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES);
  // Bit order of the per-channel input vectors: {btn, B, A}; idle levels A=B=1, btn=0.
  localparam logic [2:0]  DEB_RST = 3'b011;
  localparam logic [31:0] MAX32   = 32'(MAX_COUNT);
  localparam logic [31:0] RANGE32 = 32'(MAX_COUNT) + 32'd1;

`ifdef ENC_ACCEL_EN
  localparam int unsigned    GAP_W   = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);
`else
  // Acceleration parameters are accepted for drop-in compatibility but have no effect here.
  if ((ACCEL_STEP == 0) && (ACCEL_WINDOW == 0)) begin : g_accel_unused
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_R1,
    S_R2,
    S_R3,
    S_L1,
    S_L2,
    S_L3
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [2:0]       raw_c;
    logic [2:0]       s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
    logic [DEB_W-1:0] dcnt_q [3];
    logic [DEB_W-1:0] dcnt_d [3];
    logic             btn_dly_q, btn_dly_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic             step_q, step_d;
    logic             bpulse_q, bpulse_d;
    logic [1:0]       ab_c;
    logic             cw_c, ccw_c, btn_rise_c;
    logic [31:0]      inc_c, sum_c;
    logic [CNT_W-1:0] nxt_c;
`ifdef ENC_ACCEL_EN
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    assign raw_c = {btn_in[i], b_in[i], a_in[i]};
    assign ab_c  = {deb_q[0], deb_q[1]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q      <= DEB_RST;
        s2_q      <= DEB_RST;
        deb_q     <= DEB_RST;
        for (int k = 0; k < 3; k++) dcnt_q[k] <= '0;
        btn_dly_q <= 1'b0;
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        dir_q     <= '0;
        step_q    <= 1'b0;
        bpulse_q  <= 1'b0;
`ifdef ENC_ACCEL_EN
        gap_q     <= GAP_SAT;
`endif
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        deb_q     <= deb_d;
        for (int k = 0; k < 3; k++) dcnt_q[k] <= dcnt_d[k];
        btn_dly_q <= btn_dly_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        dir_q     <= dir_d;
        step_q    <= step_d;
        bpulse_q  <= bpulse_d;
`ifdef ENC_ACCEL_EN
        gap_q     <= gap_d;
`endif
      end
    end

    // Two-flop synchroniser followed by a stability counter per input.
    always_comb begin
      s1_d  = raw_c;
      s2_d  = s1_q;
      deb_d = deb_q;
      for (int k = 0; k < 3; k++) begin
        dcnt_d[k] = '0;
        if (s2_q[k] != deb_q[k]) begin
          if (dcnt_q[k] == DEB_W'(DEB_CYCLES - 1)) begin
            deb_d[k] = s2_q[k];
          end else begin
            dcnt_d[k] = dcnt_q[k] + DEB_W'(1);
          end
        end
      end
    end

    // Full-step decoder; a step is only credited on return to the 11 detent.
    always_comb begin
      state_d = state_q;
      cw_c    = 1'b0;
      ccw_c   = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ab_c == 2'b01)      state_d = S_R1;
          else if (ab_c == 2'b10) state_d = S_L1;
        end
        S_R1: begin
          if (ab_c == 2'b00)      state_d = S_R2;
          else if (ab_c == 2'b11) state_d = S_IDLE;
        end
        S_R2: begin
          if (ab_c == 2'b10)      state_d = S_R3;
          else if (ab_c == 2'b01) state_d = S_R1;
        end
        S_R3: begin
          if (ab_c == 2'b11) begin
            state_d = S_IDLE;
            cw_c    = 1'b1;
          end else if (ab_c == 2'b00) begin
            state_d = S_R2;
          end
        end
        S_L1: begin
          if (ab_c == 2'b00)      state_d = S_L2;
          else if (ab_c == 2'b11) state_d = S_IDLE;
        end
        S_L2: begin
          if (ab_c == 2'b01)      state_d = S_L3;
          else if (ab_c == 2'b10) state_d = S_L1;
        end
        S_L3: begin
          if (ab_c == 2'b11) begin
            state_d = S_IDLE;
            ccw_c   = 1'b1;
          end else if (ab_c == 2'b00) begin
            state_d = S_L2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Count update; a button edge overrides any step in the same cycle.
    always_comb begin
      btn_dly_d  = deb_q[2];
      btn_rise_c = deb_q[2] & ~btn_dly_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      bpulse_d   = btn_rise_c;
      inc_c      = 32'd1;
      sum_c      = 32'd0;
      nxt_c      = cnt_q;
`ifdef ENC_ACCEL_EN
      gap_d = (gap_q < GAP_SAT) ? gap_q + GAP_W'(1) : gap_q;
      if (gap_q < GAP_SAT) inc_c = 32'(ACCEL_STEP);
`endif
      if (cw_c) begin
        sum_c = 32'(cnt_q) + inc_c;
        if (sum_c > MAX32) nxt_c = (WRAP_MODE != 0) ? CNT_W'(sum_c - RANGE32) : CNT_W'(MAX32);
        else               nxt_c = CNT_W'(sum_c);
      end else if (ccw_c) begin
        sum_c = 32'(cnt_q);
        if (sum_c >= inc_c) nxt_c = CNT_W'(sum_c - inc_c);
        else                nxt_c = (WRAP_MODE != 0) ? CNT_W'(sum_c + RANGE32 - inc_c) : '0;
      end

      if (btn_rise_c) begin
        cnt_d = '0;
        dir_d = 2'b00;
`ifdef ENC_ACCEL_EN
        gap_d = GAP_SAT;
`endif
      end else if (en[i] && (cw_c || ccw_c)) begin
        cnt_d  = nxt_c;
        dir_d  = cw_c ? 2'b01 : 2'b10;
        step_d = (nxt_c != cnt_q);
`ifdef ENC_ACCEL_EN
        gap_d  = '0;
`endif
      end
    end

    assign count_out[i*CNT_W +: CNT_W] = cnt_q;
    assign dir_out[i*2 +: 2]           = dir_q;
    assign step_pulse[i]               = step_q;
    assign btn_pulse[i]                = bpulse_q;
  end

endmodule

// File: doc/quad_enc_multi.md
Name: quad_enc_multi

Overview:
Parametrised multi-channel rotary encoder front end. Each channel synchronises, debounces and full-step decodes a quadrature pair (A/B) plus a push button, and keeps a bounded position count with wrap or saturate arithmetic. Instantiated between the Pmod connector pins and the display/LED logic. Replaces the single-channel debouncer+encoder pair.

Parameters:
NUM_CH, 2, number of independent encoder channels (1..8)
CNT_W, 5, width of each position counter
MAX_COUNT, 31, upper count bound (must be < 2**CNT_W); lower bound is 0
DEB_CYCLES, 1000, consecutive stable cycles required before a debounced input changes (>=2)
WRAP_MODE, 1, 1 = wrap MAX_COUNT<->0; 0 = saturate at 0 and MAX_COUNT
ACCEL_WINDOW, 200000, cycles between steps that qualify as fast turning (ENC_ACCEL_EN only)
ACCEL_STEP, 4, step size when fast turning (ENC_ACCEL_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
a_in  in  NUM_CH  raw encoder A per channel
b_in  in  NUM_CH  raw encoder B per channel
btn_in  in  NUM_CH  raw push button per channel, active-high
en  in  NUM_CH  per-channel count enable
count_out  out  NUM_CH*CNT_W  position counts, channel i in bits [i*CNT_W +: CNT_W]
dir_out  out  NUM_CH*2  per channel: bit0 = last step CW, bit1 = last step CCW
step_pulse  out  NUM_CH  one-cycle strobe when that channel's count_out changes due to a step
btn_pulse  out  NUM_CH  one-cycle strobe on debounced button press

Behaviour:
- Reset (async, rst=1): count_out=0, dir_out=0, step_pulse=0, btn_pulse=0, all FSMs IDLE, debounced A/B=1, debounced btn=0, sync flops loaded with those values, debounce counters 0.
- Synchroniser: 2-flop per raw input. Debounce: per-signal counter; increments while sync value != debounced value, clears when equal; at DEB_CYCLES-1 the debounced value takes the sync value and the counter clears. Raw-to-debounced latency = 2 + DEB_CYCLES cycles. Glitch shorter than DEB_CYCLES: no effect.
- Decoder FSM per channel on debounced {A,B}, detent at 11:
  IDLE: 01->R1, 10->L1, else stay.
  R1: 00->R2, 11->IDLE, else stay. R2: 10->R3, 01->R1, else stay. R3: 11->IDLE + CW step, 00->R2, else stay.
  L1: 00->L2, 11->IDLE, else stay. L2: 01->L3, 10->L1, else stay. L3: 11->IDLE + CCW step, 00->L2, else stay.
  Aborted rotations (return to 11 from R1/L1) produce no step.
- Step handling, registered, same cycle for count_out, dir_out, step_pulse (1 cycle after debounced AB reaches 11):
  CW: count+1; CCW: count-1. WRAP_MODE=1: MAX_COUNT+1 -> 0, 0-1 -> MAX_COUNT. WRAP_MODE=0: clamp; step_pulse not asserted if clamped count unchanged; dir_out still updates.
  dir_out = 01 after CW, 10 after CCW; held until next step.
- en[i]=0: FSM keeps tracking, count/dir/step_pulse frozen; button still works.
- Button: debounced rising edge -> btn_pulse=1 for one cycle, count_out=0, dir_out=00 next cycle. Held button: single pulse. Button edge and step in same cycle: button wins, step discarded, step_pulse=0.
- Channels fully independent; no shared state.
- Reset mid-rotation: FSM returns to IDLE, partial step discarded.

Optional Feature:
ENC_ACCEL_EN. Defined: per-channel gap counter (saturating, cleared on each step); a step arriving while gap < ACCEL_WINDOW moves by ACCEL_STEP instead of 1, using the same wrap/saturate rule (wrap modulo MAX_COUNT+1; saturate clamps). First step after reset or button always 1. Undefined: gap counters absent, every step is +/-1, ACCEL_* parameters ignored.

Test Plan:
NUM_CH=2, CNT_W=5, MAX_COUNT=9, DEB_CYCLES=4, accel off unless stated.
- CW sequence 11-01-00-10-11 on ch0 (each held 10 cycles) -> count ch0 0->1, dir 01, one step_pulse; ch1 unchanged.
- CCW sequence from reset, WRAP_MODE=1 -> count 9, dir 10; repeat with WRAP_MODE=0 -> count 0, no step_pulse, dir 10.
- 10 CW steps WRAP_MODE=1 -> 1..9 then 0; WRAP_MODE=0 -> stops at 9, 10th step no step_pulse.
- 2-cycle glitch on a_in, and aborted 11-01-11 -> no step, FSM IDLE.
- Count 5, btn_in held 50 cycles -> single btn_pulse, count 0, dir 00; button edge coincident with CW step -> count 0, no step_pulse; en=0 during CW -> count held.
- ENC_ACCEL_EN, ACCEL_WINDOW=100, ACCEL_STEP=4: two CW steps 40 cycles apart from 0 -> 1 then 5; third step 300 cycles later -> 6; rst asserted mid-sequence -> all outputs 0 asynchronously.
